morse_round_timer: RTL and testbench
====================================

Name: morse_round_timer

Overview:
- Upstream stage of the Morse display decoder. It picks the digit for each game round and drives that decoder's number input and its three difficulty-specific timeout inputs.
- A round starts on a start pulse. A free-running LFSR supplies a pseudo-random digit 0-9, and a per-difficulty countdown runs against the player's answer.
- The block reports correct/wrong, the remaining seconds and a running score to game control.

Parameters:
- TICK_DIV, 50000000, clock cycles per one-second tick (set to 4 in simulation).
- SECS_EASY, 10, round length in seconds for difficulty 00.
- SECS_MED, 6, round length in seconds for difficulty 01.
- SECS_HARD, 3, round length in seconds for difficulty 10/11.
- LFSR_SEED, 8'hA5, non-zero LFSR reset value.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle synchronous pulse (debounced button) that begins a round.
- difficulty  input  2  00 easy, 01 med, 10 hard, 11 treated as hard.
- logout  input  1  level from game control; aborts everything to IDLE.
- answer  input  4  player's digit.
- answer_valid  input  1  one-cycle strobe qualifying answer.
- number  output  4  digit for the decoder; 4'hF = blank.
- timeout  output  1  easy round expired.
- timeout_med  output  1  medium round expired.
- timeout_hard  output  1  hard round expired.
- round_active  output  1  high in RUN.
- correct  output  1  one-cycle pulse, answer matched.
- wrong  output  1  one-cycle pulse, answer mismatched.
- time_left  output  4  remaining whole seconds.
- score  output  7  correct answers, saturating at 99.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE, LFSR loads LFSR_SEED.
  - number=4'hF; time_left=0; score=0; all other outputs 0.
- Registers:
  - All outputs are registered.
  - The LFSR is 8-bit Fibonacci, taps 8,6,5,4, shifting every cycle in every state. It never reaches all-zero.
- Digit selection: d = lfsr[3:0]; number = d if d<10, else d-10.
- IDLE:
  - number=4'hF, round_active=0, timeouts hold their value.
  - start=1 goes to LOAD. start and logout in the same cycle: logout wins.
- LOAD (1 cycle):
  - Latch difficulty and the digit into number.
  - Load time_left with the SECS_* value for the latched difficulty, clear the prescaler, clear all three timeouts.
  - Next state RUN.
  - Latency: start at cycle N gives number valid and round_active=1 from cycle N+2.
- RUN:
  - The prescaler counts 0..TICK_DIV-1; the wrap cycle is a tick.
  - On a tick, time_left decrements.
  - On a tick with time_left==1: time_left becomes 0 and the state goes to TIMEOUT.
  - answer_valid with answer==number: correct pulses for 1 cycle, score increments (held at 99 if already 99), go to RESULT.
  - answer_valid with answer!=number: wrong pulses for 1 cycle, go to RESULT.
  - answer_valid on the same cycle as the final tick: the answer wins, with no timeout.
  - start during RUN is ignored; difficulty changes are ignored until the next LOAD.
- TIMEOUT:
  - Assert exactly one of timeout/timeout_med/timeout_hard according to the latched difficulty. It stays high until the next LOAD, logout or reset.
  - number holds its value (the decoder blanks on timeout).
  - round_active=0; answer_valid is ignored.
  - start goes to LOAD.
- RESULT:
  - number and time_left are held, round_active=0, answer_valid is ignored.
  - start goes to LOAD.
- logout=1 (any state, synchronous):
  - Next cycle: IDLE, number=4'hF, timeouts=0, time_left=0, prescaler=0.
  - score is kept; only rst clears score.

Test Plan (TICK_DIV=4):
- Reset, then release rst -> number=4'hF, score=0, all flags 0; LFSR first digit is deterministic from 8'hA5, and the bench checks it against a model.
- difficulty=00, start, no answer -> round_active for 40 cycles after LOAD; time_left steps 10..0 every 4 cycles; timeout=1 only, timeout_med=timeout_hard=0; start then clears timeout.
- difficulty=01, start, answer_valid with answer==number at 5 cycles into RUN -> correct pulse one cycle, score 0->1, state RESULT, time_left frozen at 5.
- difficulty=10, answer mismatched -> wrong pulse, score unchanged; second round with answer_valid on the final-tick cycle -> correct/wrong asserted, timeout_hard stays 0.
- Mid-RUN logout=1 -> next cycle number=4'hF, round_active=0, score preserved; start during RUN ignored; asynchronous rst mid-RUN clears all immediately.
- 100 forced-correct rounds -> score saturates at 99; all generated numbers are in 0..9.

Source files
------------

// File: rtl/morse_round_timer.sv
// morse_round_timer: picks a pseudo-random digit per game round, runs a
// per-difficulty countdown against the player's answer, and reports
// correct/wrong, remaining seconds and a saturating score.
//
// Strobes: start and answer_valid are single-cycle pulses sampled on the
// rising clock edge; there is no back-pressure. logout is a level that
// aborts to IDLE on the next edge and wins over start.
module morse_round_timer #(
    parameter int         TICK_DIV  = 50000000,
    parameter int         SECS_EASY = 10,
    parameter int         SECS_MED  = 6,
    parameter int         SECS_HARD = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] difficulty,
    input  logic       logout,
    input  logic [3:0] answer,
    input  logic       answer_valid,
    output logic [3:0] number,
    output logic       timeout,
    output logic       timeout_med,
    output logic       timeout_hard,
    output logic       round_active,
    output logic       correct,
    output logic       wrong,
    output logic [3:0] time_left,
    output logic [6:0] score
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_TIMEOUT = 3'd3;
    localparam logic [2:0] S_RESULT  = 3'd4;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [3:0] SECS_EASY_L = 4'(SECS_EASY);
    localparam logic [3:0] SECS_MED_L  = 4'(SECS_MED);
    localparam logic [3:0] SECS_HARD_L = 4'(SECS_HARD);

    logic [2:0]    state;
    logic [7:0]    lfsr;
    logic [PW-1:0] presc;
    logic [1:0]    diff_q;
    logic [3:0]    lfsr_digit;
    logic [3:0]    load_secs;
    logic          tick;
    logic          lfsr_fb;

    // Fibonacci feedback for taps 8,6,5,4 (bit 8 is lfsr[7]).
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Prescaler wrap marks the one-second tick while a round is running.
    assign tick = (state == S_RUN) && (presc == PRESC_MAX);

    // Fold the low LFSR nibble into 0..9.
    always_comb begin
        lfsr_digit = lfsr[3:0];
        if (lfsr[3:0] > 4'd9) begin
            lfsr_digit = lfsr[3:0] - 4'd10;
        end
    end

    // Round length for the difficulty being latched; 11 counts as hard.
    always_comb begin
        load_secs = SECS_HARD_L;
        case (difficulty)
            2'b00:   load_secs = SECS_EASY_L;
            2'b01:   load_secs = SECS_MED_L;
            default: load_secs = SECS_HARD_L;
        endcase
    end

    // Free-running LFSR; shifts every cycle in every state, never all-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    // Round control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            presc        <= '0;
            diff_q       <= 2'b00;
            number       <= 4'hF;
            timeout      <= 1'b0;
            timeout_med  <= 1'b0;
            timeout_hard <= 1'b0;
            round_active <= 1'b0;
            correct      <= 1'b0;
            wrong        <= 1'b0;
            time_left    <= 4'd0;
            score        <= 7'd0;
        end else begin
            correct <= 1'b0;
            wrong   <= 1'b0;
            if (logout) begin
                // Score survives a logout; only reset clears it.
                state        <= S_IDLE;
                number       <= 4'hF;
                timeout      <= 1'b0;
                timeout_med  <= 1'b0;
                timeout_hard <= 1'b0;
                time_left    <= 4'd0;
                presc        <= '0;
                round_active <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        number       <= 4'hF;
                        round_active <= 1'b0;
                        if (start) begin
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        diff_q       <= difficulty;
                        number       <= lfsr_digit;
                        time_left    <= load_secs;
                        presc        <= '0;
                        timeout      <= 1'b0;
                        timeout_med  <= 1'b0;
                        timeout_hard <= 1'b0;
                        round_active <= 1'b1;
                        state        <= S_RUN;
                    end
                    S_RUN: begin
                        if (answer_valid) begin
                            // An answer on the final tick beats the timeout;
                            // time_left freezes at its current value.
                            round_active <= 1'b0;
                            state        <= S_RESULT;
                            if (answer == number) begin
                                correct <= 1'b1;
                                if (score < 7'd99) begin
                                    score <= score + 7'd1;
                                end
                            end else begin
                                wrong <= 1'b1;
                            end
                        end else begin
                            presc <= tick ? '0 : presc + PW'(1);
                            if (tick) begin
                                time_left <= time_left - 4'd1;
                                if (time_left == 4'd1) begin
                                    round_active <= 1'b0;
                                    state        <= S_TIMEOUT;
                                    case (diff_q)
                                        2'b00:   timeout      <= 1'b1;
                                        2'b01:   timeout_med  <= 1'b1;
                                        default: timeout_hard <= 1'b1;
                                    endcase
                                end
                            end
                        end
                    end
                    S_TIMEOUT, S_RESULT: begin
                        round_active <= 1'b0;
                        if (start) begin
                            state <= S_LOAD;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_round_timer.sv
// Directed bench for morse_round_timer with a one-second tick of 4 cycles.
module tb_morse_round_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] difficulty;
    logic       logout;
    logic [3:0] answer;
    logic       answer_valid;
    logic [3:0] number;
    logic       timeout;
    logic       timeout_med;
    logic       timeout_hard;
    logic       round_active;
    logic       correct;
    logic       wrong;
    logic [3:0] time_left;
    logic [6:0] score;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_lfsr;
    logic [3:0] exp_q[$];
    logic [3:0] cur_num;
    int         exp_score;

    morse_round_timer #(.TICK_DIV(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .difficulty   (difficulty),
        .logout       (logout),
        .answer       (answer),
        .answer_valid (answer_valid),
        .number       (number),
        .timeout      (timeout),
        .timeout_med  (timeout_med),
        .timeout_hard (timeout_hard),
        .round_active (round_active),
        .correct      (correct),
        .wrong        (wrong),
        .time_left    (time_left),
        .score        (score)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded with 8'hA5.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 8'hA5;
        else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [3:0] to_digit(input logic [7:0] l);
        logic [3:0] d;
        d = l[3:0];
        return (d < 4'd10) ? d : d - 4'd10;
    endfunction

    function automatic logic [3:0] secs_for(input logic [1:0] d);
        case (d)
            2'b00:   return 4'd10;
            2'b01:   return 4'd6;
            default: return 4'd3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start; returns #1 after the edge entering the first RUN cycle.
    task automatic start_round(input logic [1:0] diff);
        difficulty = diff;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(to_digit(m_lfsr));   // LFSR value seen during LOAD
        @(posedge clk); #1;
        cur_num = exp_q.pop_front();
        check("number", number, cur_num);
        check("number_range", number <= 4'd9, 1);
        check("round_active_run", round_active, 1);
        check("time_left_load", time_left, secs_for(diff));
        check("timeouts_cleared", {timeout, timeout_med, timeout_hard}, 0);
    endtask

    task automatic give_answer(input logic [3:0] a);
        answer = a;
        answer_valid = 1'b1;
        @(posedge clk); #1;
        answer_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        difficulty = 2'b00;
        logout = 1'b0;
        answer = 4'd0;
        answer_valid = 1'b0;
        exp_score = 0;
        cur_num = 4'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_number", number, 4'hF);
        check("rst_score", score, 0);
        check("rst_time_left", time_left, 0);
        check("rst_flags", {timeout, timeout_med, timeout_hard, round_active, correct, wrong}, 0);
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        check("idle_number", number, 4'hF);

        // Easy round expires: 10 seconds of 4 cycles each
        start_round(2'b00);
        for (int k = 1; k <= 10; k++) begin
            cycles(4);
            check("easy_time_left", time_left, 10 - k);
            check("easy_round_active", round_active, (k < 10) ? 1 : 0);
        end
        check("easy_timeout", timeout, 1);
        check("easy_timeout_med", timeout_med, 0);
        check("easy_timeout_hard", timeout_hard, 0);
        check("timeout_number_held", number, cur_num);
        cycles(3);
        check("timeout_holds", timeout, 1);
        give_answer(cur_num);
        check("timeout_ignores_answer", correct, 0);
        check("timeout_score", score, 0);

        // Medium round, correct answer 5 cycles into RUN
        start_round(2'b01);
        cycles(4);
        check("med_time_left_before", time_left, 5);
        give_answer(cur_num);
        exp_score = 1;
        check("med_correct", correct, 1);
        check("med_wrong", wrong, 0);
        check("med_score", score, exp_score);
        check("med_round_active", round_active, 0);
        check("med_time_frozen", time_left, 5);
        cycles(1);
        check("med_correct_pulse_end", correct, 0);
        cycles(6);
        check("med_time_still_frozen", time_left, 5);
        check("med_no_timeout", timeout_med, 0);

        // Hard round, mismatched answer
        start_round(2'b10);
        cycles(1);
        give_answer((cur_num == 4'd9) ? 4'd0 : cur_num + 4'd1);
        check("hard_wrong", wrong, 1);
        check("hard_correct", correct, 0);
        check("hard_score", score, exp_score);
        cycles(1);
        check("hard_wrong_pulse_end", wrong, 0);

        // Difficulty 11 as hard, answer on the final-tick cycle
        start_round(2'b11);
        cycles(11);
        check("final_tick_time_left", time_left, 1);
        check("final_tick_active", round_active, 1);
        give_answer(cur_num);
        exp_score = 2;
        check("final_tick_correct", correct, 1);
        check("final_tick_no_timeout", timeout_hard, 0);
        check("final_tick_score", score, exp_score);
        cycles(6);
        check("final_tick_timeout_stays_low", timeout_hard, 0);
        check("final_tick_inactive", round_active, 0);

        // start ignored in RUN, then logout mid-RUN
        start_round(2'b00);
        cycles(1);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        check("run_start_ignored_active", round_active, 1);
        check("run_start_ignored_number", number, cur_num);
        check("run_start_ignored_time", time_left, 10);
        logout = 1'b1;
        cycles(1);
        logout = 1'b0;
        check("logout_number", number, 4'hF);
        check("logout_active", round_active, 0);
        check("logout_time_left", time_left, 0);
        check("logout_score_kept", score, exp_score);

        // logout beats start in IDLE
        start = 1'b1;
        logout = 1'b1;
        cycles(1);
        start = 1'b0;
        logout = 1'b0;
        cycles(2);
        check("logout_wins_active", round_active, 0);
        check("logout_wins_number", number, 4'hF);

        // Asynchronous reset mid-RUN
        start_round(2'b01);
        cycles(2);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_number", number, 4'hF);
        check("async_rst_active", round_active, 0);
        check("async_rst_time_left", time_left, 0);
        check("async_rst_score", score, 0);
        exp_score = 0;
        @(negedge clk);
        rst = 1'b1;
        cycles(1);

        // 100 forced-correct rounds, score saturates at 99
        for (int r = 0; r < 100; r++) begin
            start_round(2'b10);
            give_answer(cur_num);
            if (exp_score < 99) exp_score++;
            check("sat_correct", correct, 1);
            check("sat_score", score, exp_score);
        end
        check("sat_final_score", score, 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
